// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, LSB first,
// one full-adder cell plus one carry flop; WIDTH cycles per operation.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_ns,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic carry, sum, carry_nx, last;

    // b_sr already holds ~b for subtract, so the cell is always a plain adder
    always_comb begin
        sum = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nx = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        last = cnt == CW'(WIDTH - 1);
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                   (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr  <= a;
            b_sr  <= a_ns ? b : ~b;
            carry <= ~a_ns;
            cnt   <= '0;
        end else if (state == RUN) begin
            result <= {sum, result[WIDTH-1:1]};
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= carry_nx;
            if (!last) cnt <= cnt + CW'(1);
            if (last) begin
                cout <= carry_nx;
                ovf  <= carry ^ carry_nx;
            end
        end
    end

    assign busy = state == RUN;
    assign done = state == DONE;
endmodule
